// File: rtl/csr_timer_ctrl.sv
// csr_timer_ctrl: constant-timer sequencer (TCFG/TVAL/TI) plus the rdcnt
// read port onto the free-running 64-bit stable counter. All outputs are
// registered; the next-state logic is a single always_comb feeding flops.
module csr_timer_ctrl #(
  parameter int          TIMER_W = 32,
  parameter logic [31:0] TID     = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        stable_cnt,
  input  logic               tcfg_we,
  input  logic [TIMER_W-1:0] tcfg_wdata,
  input  logic               ticlr_we,
  input  logic [TIMER_W-1:0] ticlr_wdata,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               timer_int,
  input  logic               rdcnt_req,
  input  logic [1:0]         rdcnt_op,
  output logic               rdcnt_valid,
  output logic [31:0]        rdcnt_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic               ti_q, ti_d;
  logic               rv_q, rv_d;
  logic [31:0]        rd_q, rd_d;
  logic               expire;

  // Reload values: InitVal with the two low bits forced to zero.
  logic [TIMER_W-1:0] reload_wr, reload_cfg;
  assign reload_wr  = {tcfg_wdata[TIMER_W-1:2], 2'b00};
  assign reload_cfg = {tcfg_q[TIMER_W-1:2], 2'b00};

  // Only the CLR bit of a TICLR write is meaningful.
  logic unused_ticlr;
  assign unused_ticlr = ^ticlr_wdata[TIMER_W-1:1];

  // Next-state: a TCFG write overrides the countdown; expiry sets TI and
  // beats a same-cycle clear so no event is dropped.
  always_comb begin
    state_d = state_q;
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    ti_d    = ti_q;
    rv_d    = rdcnt_req;
    rd_d    = rd_q;
    expire  = 1'b0;

    if (tcfg_we) begin
      tcfg_d = tcfg_wdata;
      if (tcfg_wdata[0]) begin
        tval_d  = reload_wr;
        state_d = RUN;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (tval_q != '0) begin
            tval_d = tval_q - TIMER_W'(1);
          end else begin
            expire = 1'b1;
            if (tcfg_q[1]) tval_d  = reload_cfg;
            else           state_d = DONE;
          end
        end
        default: ;
      endcase
    end

    if (expire)                          ti_d = 1'b1;
    else if (ticlr_we && ticlr_wdata[0]) ti_d = 1'b0;

    if (rdcnt_req) begin
      case (rdcnt_op)
        2'b00:   rd_d = stable_cnt[31:0];
        2'b01:   rd_d = stable_cnt[63:32];
        2'b10:   rd_d = TID;
        default: rd_d = 32'h0;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcfg_q  <= '0;
      tval_q  <= '0;
      ti_q    <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      tcfg_q  <= tcfg_d;
      tval_q  <= tval_d;
      ti_q    <= ti_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  end

  assign tcfg        = tcfg_q;
  assign tval        = tval_q;
  assign timer_int   = ti_q;
  assign rdcnt_valid = rv_q;
  assign rdcnt_data  = rd_q;

endmodule

// File: tb/tb_csr_timer_ctrl.sv
// Scoreboard bench for csr_timer_ctrl: the stimulus process steps a
// behavioural timer model each cycle and queues expectations; a monitor
// on the falling edge pops and compares against the DUT.
module tb_csr_timer_ctrl;
  localparam int          W   = 32;
  localparam logic [31:0] TID = 32'h0;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   stable_cnt;
  logic          tcfg_we;
  logic [W-1:0]  tcfg_wdata;
  logic          ticlr_we;
  logic [W-1:0]  ticlr_wdata;
  logic [W-1:0]  tcfg, tval;
  logic          timer_int;
  logic          rdcnt_req;
  logic [1:0]    rdcnt_op;
  logic          rdcnt_valid;
  logic [31:0]   rdcnt_data;

  csr_timer_ctrl #(.TIMER_W(W), .TID(TID)) dut (
    .clk(clk), .rst(rst), .stable_cnt(stable_cnt),
    .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
    .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata),
    .tcfg(tcfg), .tval(tval), .timer_int(timer_int),
    .rdcnt_req(rdcnt_req), .rdcnt_op(rdcnt_op),
    .rdcnt_valid(rdcnt_valid), .rdcnt_data(rdcnt_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] tcfg;
    logic [W-1:0] tval;
    logic         ti;
    logic         rv;
  } exp_t;

  exp_t        tq[$];
  logic [31:0] rq[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  // Reference model state
  logic [W-1:0] m_tcfg, m_tval;
  logic         m_run, m_ti, m_rv;
  logic [31:0]  m_rd;
  int           m_events;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Step the model by one clock edge using the currently driven inputs,
  // queue what the DUT must show afterwards, then advance the clock.
  task automatic cyc();
    exp_t e;
    logic set;
    set = 1'b0;
    if (rst) begin
      m_tcfg = '0; m_tval = '0; m_run = 1'b0; m_ti = 1'b0;
      m_rv = 1'b0; m_rd = 32'h0;
    end else begin
      if (tcfg_we) begin
        m_tcfg = tcfg_wdata;
        if (tcfg_wdata[0]) begin
          m_tval = tcfg_wdata & ~W'(3);
          m_run  = 1'b1;
        end else begin
          m_run = 1'b0;
        end
      end else if (m_run) begin
        if (m_tval != 0) m_tval = m_tval - 1;
        else begin
          set = 1'b1;
          m_events++;
          if (m_tcfg[1]) m_tval = m_tcfg & ~W'(3);
          else           m_run = 1'b0;
        end
      end
      if (set) m_ti = 1'b1;
      else if (ticlr_we && ticlr_wdata[0]) m_ti = 1'b0;
      m_rv = rdcnt_req;
      if (rdcnt_req) begin
        case (rdcnt_op)
          2'd0:    m_rd = stable_cnt[31:0];
          2'd1:    m_rd = stable_cnt[63:32];
          2'd2:    m_rd = TID;
          default: m_rd = 32'h0;
        endcase
      end
    end
    e.tcfg = m_tcfg; e.tval = m_tval; e.ti = m_ti; e.rv = m_rv;
    tq.push_back(e);
    if (m_rv) rq.push_back(m_rd);
    @(posedge clk);
    #1;
    tcfg_we = 1'b0; ticlr_we = 1'b0; rdcnt_req = 1'b0;
  endtask

  task automatic wr_tcfg(input logic [W-1:0] d);
    tcfg_we = 1'b1; tcfg_wdata = d; cyc();
  endtask

  // Monitor: one expectation per cycle, plus a read response when valid.
  always @(negedge clk) begin
    if (tq.size() > 0) begin
      exp_t e;
      e = tq.pop_front();
      chk("tcfg", 64'(tcfg), 64'(e.tcfg));
      chk("tval", 64'(tval), 64'(e.tval));
      chk("timer_int", 64'(timer_int), 64'(e.ti));
      chk("rdcnt_valid", 64'(rdcnt_valid), 64'(e.rv));
      if (rdcnt_valid === 1'b1) begin
        if (rq.size() == 0) chk("rdcnt_unexpected", 64'(rdcnt_data), 64'hDEAD_0000_0000_0000);
        else chk("rdcnt_data", 64'(rdcnt_data), 64'(rq.pop_front()));
      end
    end
  end

  int guard;
  int ev0;

  initial begin
    rst = 1'b1; stable_cnt = 64'h0; tcfg_we = 1'b0; tcfg_wdata = '0;
    ticlr_we = 1'b0; ticlr_wdata = '0; rdcnt_req = 1'b0; rdcnt_op = 2'd0;
    m_events = 0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Reset during a countdown at tval=5
    wr_tcfg(W'('h19));
    guard = 0;
    while (m_tval != 5 && guard < 100) begin cyc(); guard++; end
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    repeat (8) cyc();

    // One-shot InitVal=3: expect exactly one event over a long window
    ev0 = m_events;
    wr_tcfg(W'('h0D));
    repeat (65) cyc();
    chk("oneshot_events", 64'(m_events - ev0), 64'd1);

    // Periodic R=4 with clear racing an expiry, then a clear one cycle later
    ticlr_we = 1'b1; ticlr_wdata = W'(1); cyc();
    wr_tcfg(W'('h07));
    repeat (12) cyc();
    guard = 0;
    while (!(m_run && m_tval == 0) && guard < 20) begin cyc(); guard++; end
    ticlr_we = 1'b1; ticlr_wdata = W'(1); cyc();
    ticlr_we = 1'b1; ticlr_wdata = W'(1); cyc();
    ticlr_we = 1'b1; ticlr_wdata = W'(2); cyc();
    repeat (10) cyc();

    // Reconfigure mid-run: freeze at 6, then restart with InitVal=2
    wr_tcfg(W'('h23));
    guard = 0;
    while (m_tval != 6 && guard < 100) begin cyc(); guard++; end
    wr_tcfg(W'('h00));
    repeat (5) cyc();
    wr_tcfg(W'('h09));
    repeat (12) cyc();

    // Counter reads, four consecutive ops
    stable_cnt = 64'h0000_0001_FFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      rdcnt_req = 1'b1; rdcnt_op = 2'(i); cyc();
    end
    repeat (3) cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      stable_cnt = {$urandom, $urandom};
      if ($urandom_range(0, 39) == 0) begin
        tcfg_we = 1'b1;
        tcfg_wdata = W'({$urandom_range(0, 7), 2'b00}) | W'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) tcfg_wdata = $urandom;
      end
      if ($urandom_range(0, 7) == 0) begin
        ticlr_we = 1'b1; ticlr_wdata = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        rdcnt_req = 1'b1; rdcnt_op = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      cyc();
      rst = 1'b0;
    end

    repeat (2) cyc();
    @(negedge clk); #1;
    chk("tq_drained", 64'(tq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
